// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU control path: opcodes, ALU
//               function selects, control FSM states and the bit positions
//               of the instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcodes (INSTR[31:24])
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // ALU function selects, shared with the ALU
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Control FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2
  } state_t;

  // Instruction field LSB positions
  localparam int OPCODE_LSB = 24;  // 8 bits
  localparam int DEST_LSB   = 16;  // 8 bits, DEST[2:0] or branch OFFSET
  localparam int SRC1_LSB   = 8;   // 3 bits
  localparam int SRC2_LSB   = 0;   // 8 bits, SRC2[2:0] or IMM

endpackage
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : Combinational next-PC computation. Sequential PC is pc+4;
//               a jump, or a branch whose sampled ZERO flag is set, adds the
//               sign-extended word offset (offset<<2). Modulo 2^PC_WIDTH.
// Ports       : pc           - current PC
//               offset       - signed 8-bit word offset
//               is_jump      - unconditional jump
//               is_branch    - branch-on-equal
//               zero_sampled - ALU ZERO captured at the end of EXEC
//               pc_next      - next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter int PC_WIDTH = 32  // must be >= 10 to hold the shifted offset
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          offset,
  input  logic                is_jump,
  input  logic                is_branch,
  input  logic                zero_sampled,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic [PC_WIDTH-1:0] offset_ext;
  logic                taken;

  assign offset_ext = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
  assign taken      = is_jump | (is_branch & zero_sampled);
  assign pc_next    = pc + PC_WIDTH'(4) + (taken ? offset_ext : '0);

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Fetch/decode/sequencing stage in front of the 8-bit ALU.
//               FETCH -> EXEC (EXEC_CYCLES) -> WB -> FETCH.
// Ports       : CLK, RESET (async, active low)
//               PC, INSTR_REQ, INSTR_VALID, INSTR   - instruction fetch
//               READREG1/2, REG_OUT1/2              - register-file reads
//               WRITEREG, WRITEENABLE               - register-file write
//               ALU_DATA1/2, ALU_SELECT, ALU_ZERO   - ALU interface
//               ILLEGAL                             - sticky undefined opcode
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [PC_WIDTH-1:0] PC,
  output logic                INSTR_REQ,
  input  logic                INSTR_VALID,
  input  logic [31:0]         INSTR,
  output logic [2:0]          READREG1,
  output logic [2:0]          READREG2,
  input  logic [7:0]          REG_OUT1,
  input  logic [7:0]          REG_OUT2,
  output logic [2:0]          WRITEREG,
  output logic                WRITEENABLE,
  output logic [7:0]          ALU_DATA1,
  output logic [7:0]          ALU_DATA2,
  output logic [2:0]          ALU_SELECT,
  input  logic                ALU_ZERO,
  output logic                ILLEGAL
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t              state, state_next;
  logic [7:0]          opcode;
  logic [7:0]          dest_off;
  logic [2:0]          src1;
  logic [7:0]          src2_imm;
  logic [CNT_W-1:0]    exec_cnt;
  logic                exec_last;
  logic                zero_sampled;
  logic                illegal_reg;
  logic                started;
  logic                fetch_accept;
  logic                active;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic [7:0]          reg2_neg;
  logic                unused_bits;

  // Instruction bits [15:11] carry no field.
  assign unused_bits = ^INSTR[15:11];

  // The request is held off for one edge after reset release.
  assign INSTR_REQ    = (state == FETCH) && started;
  assign fetch_accept = INSTR_REQ && INSTR_VALID;
  assign exec_last    = (exec_cnt == CNT_LAST);
  // Operands stay driven through WB so the ALU result is stable at the write.
  assign active       = (state != FETCH);
  assign reg2_neg     = ~REG_OUT2 + 8'd1;
  assign PC           = pc_reg;
  assign ILLEGAL      = illegal_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= FETCH;
      started      <= 1'b0;
      pc_reg       <= '0;
      opcode       <= '0;
      dest_off     <= '0;
      src1         <= '0;
      src2_imm     <= '0;
      exec_cnt     <= '0;
      zero_sampled <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (fetch_accept) begin
            opcode   <= INSTR[OPCODE_LSB +: 8];
            dest_off <= INSTR[DEST_LSB +: 8];
            src1     <= INSTR[SRC1_LSB +: 3];
            src2_imm <= INSTR[SRC2_LSB +: 8];
            exec_cnt <= '0;
            if (INSTR[OPCODE_LSB +: 8] > OP_BEQ) illegal_reg <= 1'b1;
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt + CNT_W'(1);
          if (exec_last) zero_sampled <= ALU_ZERO;
        end
        WB:      pc_reg <= pc_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (fetch_accept) state_next = EXEC;
      EXEC:    if (exec_last) state_next = WB;
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    READREG1    = '0;
    READREG2    = '0;
    ALU_DATA1   = '0;
    ALU_DATA2   = '0;
    ALU_SELECT  = ALU_FWD;
    WRITEREG    = '0;
    WRITEENABLE = 1'b0;
    if (active) begin
      READREG1  = src1;
      READREG2  = src2_imm[2:0];
      ALU_DATA1 = REG_OUT1;
      case (opcode)
        OP_LOADI: begin ALU_DATA2 = src2_imm; ALU_SELECT = ALU_FWD; end
        OP_MOV:   begin ALU_DATA2 = REG_OUT2; ALU_SELECT = ALU_FWD; end
        OP_ADD:   begin ALU_DATA2 = REG_OUT2; ALU_SELECT = ALU_ADD; end
        OP_SUB:   begin ALU_DATA2 = reg2_neg; ALU_SELECT = ALU_ADD; end
        OP_AND:   begin ALU_DATA2 = REG_OUT2; ALU_SELECT = ALU_AND; end
        OP_OR:    begin ALU_DATA2 = REG_OUT2; ALU_SELECT = ALU_OR;  end
        OP_BEQ:   begin ALU_DATA2 = reg2_neg; ALU_SELECT = ALU_ADD; end
        default:  ;  // jump and undefined opcodes leave the ALU idle
      endcase
    end
    if ((state == WB) && (opcode <= OP_OR)) begin
      WRITEENABLE = 1'b1;
      WRITEREG    = dest_off[2:0];
    end
  end

  pc_next_unit #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc           (pc_reg),
    .offset       (dest_off),
    .is_jump      (opcode == OP_J),
    .is_branch    (opcode == OP_BEQ),
    .zero_sampled (zero_sampled),
    .pc_next      (pc_next)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Self-checking bench for cpu_control_unit. Directed cases plus
//               random instructions, compared against a behavioural model of
//               the instruction set (expected PC, operands, write strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  localparam int PC_WIDTH    = 32;
  localparam int EXEC_CYCLES = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic        INSTR_REQ;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTR = '0;
  logic [2:0]  READREG1, READREG2, WRITEREG, ALU_SELECT;
  logic [7:0]  REG_OUT1 = '0, REG_OUT2 = '0;
  logic        WRITEENABLE, ILLEGAL;
  logic [7:0]  ALU_DATA1, ALU_DATA2;
  logic        ALU_ZERO = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc = '0;
  logic        exp_illegal = 1'b0;

  cpu_control_unit #(
    .PC_WIDTH    (PC_WIDTH),
    .EXEC_CYCLES (EXEC_CYCLES)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTR_REQ   (INSTR_REQ),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .REG_OUT1    (REG_OUT1),
    .REG_OUT2    (REG_OUT2),
    .WRITEREG    (WRITEREG),
    .WRITEENABLE (WRITEENABLE),
    .ALU_DATA1   (ALU_DATA1),
    .ALU_DATA2   (ALU_DATA2),
    .ALU_SELECT  (ALU_SELECT),
    .ALU_ZERO    (ALU_ZERO),
    .ILLEGAL     (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (instruction-set level) ----------------
  function automatic bit ref_writes(input logic [7:0] op);
    return op <= 8'd5;
  endfunction

  function automatic bit ref_uses_alu(input logic [7:0] op);
    return (op <= 8'd7) && (op != 8'd6);
  endfunction

  function automatic logic [2:0] ref_sel(input logic [7:0] op);
    case (op)
      8'd2, 8'd3, 8'd7: return 3'd1;  // add / subtract / compare
      8'd4:             return 3'd2;
      8'd5:             return 3'd3;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] ref_data2(input logic [7:0] op, input logic [7:0] imm,
                                           input logic [7:0] r2);
    int neg;
    neg = (256 - int'(r2)) % 256;
    case (op)
      8'd0:       return imm;
      8'd3, 8'd7: return 8'(neg);
      default:    return r2;
    endcase
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [7:0] op,
                                              input logic [7:0] off, input bit zero);
    int soff;
    soff = int'($signed(off));
    if (op == 8'd6 || (op == 8'd7 && zero)) return pc + 32'd4 + 32'(soff * 4);
    return pc + 32'd4;
  endfunction

  // Runs one instruction from a FETCH state sampled #1 after an edge.
  task automatic run_instr(input logic [31:0] instr, input logic [7:0] r1, input logic [7:0] r2,
                           input bit zero, input int fetch_wait);
    logic [7:0] op;
    op       = instr[31:24];
    REG_OUT1 = r1;
    REG_OUT2 = r2;
    INSTR    = instr;
    for (int i = 0; i < fetch_wait; i++) begin
      INSTR_VALID = 1'b0;
      @(posedge CLK); #1;
      check("wait_req", INSTR_REQ, 1);
      check("wait_pc", PC, exp_pc);
      check("wait_we", WRITEENABLE, 0);
    end
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    // Anything on the fetch bus from here on must be ignored.
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTR       = $urandom;
    if (op > 8'd7) exp_illegal = 1'b1;
    check("exec_req", INSTR_REQ, 0);
    for (int e = 0; e < EXEC_CYCLES; e++) begin
      if (e > 0) begin @(posedge CLK); #1; end
      check("rdreg1", READREG1, instr[10:8]);
      check("rdreg2", READREG2, instr[2:0]);
      check("alu_d1", ALU_DATA1, r1);
      if (ref_uses_alu(op)) begin
        check("alu_d2", ALU_DATA2, ref_data2(op, instr[7:0], r2));
        check("alu_sel", ALU_SELECT, ref_sel(op));
      end
      check("exec_we", WRITEENABLE, 0);
      check("exec_pc", PC, exp_pc);
      check("exec_ill", ILLEGAL, exp_illegal);
      // Only the value present at the last EXEC edge may matter.
      ALU_ZERO = (e == EXEC_CYCLES - 1) ? zero : !zero;
    end
    @(posedge CLK); #1;
    ALU_ZERO = !zero;
    check("wb_we", WRITEENABLE, ref_writes(op));
    if (ref_writes(op)) check("wb_reg", WRITEREG, instr[18:16]);
    check("wb_pc", PC, exp_pc);
    exp_pc = ref_next_pc(exp_pc, op, instr[23:16], zero);
    @(posedge CLK); #1;
    check("next_pc", PC, exp_pc);
    check("next_req", INSTR_REQ, 1);
    check("next_we", WRITEENABLE, 0);
    check("next_ill", ILLEGAL, exp_illegal);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [7:0]  op;
    INSTR_VALID = 1'b1;
    INSTR       = 32'h0003_002A;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pc", PC, 0);
    check("rst_req", INSTR_REQ, 0);
    check("rst_ill", ILLEGAL, 0);
    check("rst_we", WRITEENABLE, 0);
    check("rst_sel", ALU_SELECT, 0);
    check("rst_d1", ALU_DATA1, 0);
    check("rst_d2", ALU_DATA2, 0);
    RESET = 1'b1;
    #1;
    check("rel_req_before_edge", INSTR_REQ, 0);
    @(posedge CLK); #1;
    check("rel_req", INSTR_REQ, 1);
    check("rel_pc", PC, 0);

    // loadi r3,0x2A
    run_instr(32'h0003_002A, 8'h77, 8'h11, 1'b0, 0);
    // sub r1, r2, r4 with REG_OUT2 = 0x05
    run_instr(32'h0301_0204, 8'h09, 8'h05, 1'b0, 0);
    // beq at PC=8, offset -2 words, taken
    run_instr(32'h07FE_0102, 8'h10, 8'h10, 1'b1, 0);
    check("beq_taken_pc", PC, 32'd4);
    run_instr(32'h0005_0011, 8'h00, 8'h00, 1'b0, 1);
    // Same branch at PC=8, not taken
    run_instr(32'h07FE_0102, 8'h10, 8'h10, 1'b0, 0);
    check("beq_fall_pc", PC, 32'd12);
    // Undefined opcode
    run_instr(32'hFF07_0707, 8'h01, 8'h02, 1'b1, 0);
    // Long fetch wait
    run_instr(32'h0102_0300, 8'h3C, 8'hC3, 1'b0, 5);

    for (int k = 0; k < 40; k++) begin
      rnd = $urandom;
      op  = 8'($urandom_range(0, 9));
      if (op > 8'd7) op = 8'($urandom_range(8, 255));
      run_instr({op, rnd[23:0]}, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    // Undefined opcode, then reset in the middle of EXEC
    INSTR       = 32'hFF00_0000;
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    check("mid_ill", ILLEGAL, 1);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_pc", PC, 0);
    check("mid_rst_req", INSTR_REQ, 0);
    check("mid_rst_ill", ILLEGAL, 0);
    check("mid_rst_we", WRITEENABLE, 0);
    @(posedge CLK); #1;
    RESET       = 1'b1;
    exp_pc      = '0;
    exp_illegal = 1'b0;
    @(posedge CLK); #1;
    check("rerel_req", INSTR_REQ, 1);
    run_instr(32'h0206_0301, 8'h40, 8'h02, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
